ctrl_pipe: RTL and testbench

- Second-generation MIPS control unit, sitting between the IF/ID register and the EX stage.
- Decodes the ID instruction into control word, ALU op and register indices, and registers them into an ID/EX pipeline register with valid/ready handshake.
- Detects load-use hazards against a parametrised-depth scoreboard of in-flight loads and inserts bubbles.
- Honours an EX-stage branch/jump flush.

---
 rtl/ctrl_pkg.sv | 67 ++++++
 rtl/ctrl_decode.sv | 117 +++++++++++
 rtl/ctrl_pipe.sv | 172 +++++++++++++++++
 tb/tb_ctrl_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the ctrl_pipe control unit: opcodes, ALU ops,
// control-word bit positions and instruction field ranges.
package ctrl_pkg;

  // Control word and ALU op widths produced by the decoder
  localparam int SIG_BITS = 10;
  localparam int ALU_BITS = 4;

  // Primary opcodes
  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_JMP   = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes that need special handling
  localparam logic [5:0] FN_JR = 6'h08;

  // ALU operations handed to EX
  localparam logic [ALU_BITS-1:0] ALU_NOP  = 4'd0;
  localparam logic [ALU_BITS-1:0] ALU_FUNC = 4'd1;
  localparam logic [ALU_BITS-1:0] ALU_ADD  = 4'd2;
  localparam logic [ALU_BITS-1:0] ALU_ADDU = 4'd3;
  localparam logic [ALU_BITS-1:0] ALU_AND  = 4'd4;
  localparam logic [ALU_BITS-1:0] ALU_OR   = 4'd5;
  localparam logic [ALU_BITS-1:0] ALU_XOR  = 4'd6;
  localparam logic [ALU_BITS-1:0] ALU_SLL  = 4'd7;
  localparam logic [ALU_BITS-1:0] ALU_SLT  = 4'd8;
  localparam logic [ALU_BITS-1:0] ALU_SLTU = 4'd9;

  // Control word bit positions
  localparam int SIG_JUMP       = 0;
  localparam int SIG_BRANCH     = 1;
  localparam int SIG_MEMWRITE   = 2;
  localparam int SIG_REGWRITE   = 3;
  localparam int SIG_MEMTOREG   = 4;
  localparam int SIG_ALUSRC_IMM = 5;
  localparam int SIG_LINK       = 6;
  localparam int SIG_REGDST_RD  = 7;
  localparam int SIG_ZEXT       = 8;
  localparam int SIG_BNE        = 9;

  // Instruction field ranges
  localparam int F_OP_HI  = 31;
  localparam int F_OP_LO  = 26;
  localparam int F_RS_HI  = 25;
  localparam int F_RS_LO  = 21;
  localparam int F_RT_HI  = 20;
  localparam int F_RT_LO  = 16;
  localparam int F_RD_HI  = 15;
  localparam int F_RD_LO  = 11;
  localparam int F_FN_HI  = 5;
  localparam int F_FN_LO  = 0;
  localparam int F_IMM_HI = 15;
  localparam int F_IMM_LO = 0;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational instruction decoder: control word, ALU op,
// destination register, source-use flags and illegal-opcode flag.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0]         i_instr,
  output logic [SIG_BITS-1:0] o_sig,
  output logic [ALU_BITS-1:0] o_alu,
  output logic [4:0]          o_wr,
  output logic [15:0]         o_imm,
  output logic                o_usesRs,
  output logic                o_usesRt,
  output logic                o_illegal
);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic [4:0] w_rt;
  logic [4:0] w_rd;

  assign w_op  = i_instr[F_OP_HI:F_OP_LO];
  assign w_fn  = i_instr[F_FN_HI:F_FN_LO];
  assign w_rt  = i_instr[F_RT_HI:F_RT_LO];
  assign w_rd  = i_instr[F_RD_HI:F_RD_LO];
  assign o_imm = i_instr[F_IMM_HI:F_IMM_LO];

  // Opcode decode; rs is assumed used unless the instruction ignores it
  always_comb begin
    o_sig     = '0;
    o_alu     = ALU_NOP;
    o_usesRs  = 1'b1;
    o_usesRt  = 1'b0;
    o_illegal = 1'b0;
    case (w_op)
      OP_R: begin
        o_usesRt = 1'b1;
        if (w_fn == FN_JR) begin
          o_sig[SIG_JUMP] = 1'b1;
        end else begin
          o_sig[SIG_REGDST_RD] = 1'b1;
          o_sig[SIG_REGWRITE]  = 1'b1;
          o_alu                = ALU_FUNC;
        end
      end
      OP_LW: begin
        o_sig[SIG_ALUSRC_IMM] = 1'b1;
        o_sig[SIG_MEMTOREG]   = 1'b1;
        o_sig[SIG_REGWRITE]   = 1'b1;
        o_alu                 = ALU_ADD;
      end
      OP_SW: begin
        o_sig[SIG_ALUSRC_IMM] = 1'b1;
        o_sig[SIG_MEMWRITE]   = 1'b1;
        o_alu                 = ALU_ADD;
        o_usesRt              = 1'b1;
      end
      OP_BEQ: begin
        o_sig[SIG_BRANCH] = 1'b1;
        o_usesRt          = 1'b1;
      end
      OP_BNE: begin
        o_sig[SIG_BRANCH] = 1'b1;
        o_sig[SIG_BNE]    = 1'b1;
        o_usesRt          = 1'b1;
      end
      OP_JMP: begin
        o_sig[SIG_JUMP] = 1'b1;
        o_usesRs        = 1'b0;
      end
      OP_JAL: begin
        o_sig[SIG_JUMP]     = 1'b1;
        o_sig[SIG_LINK]     = 1'b1;
        o_sig[SIG_REGWRITE] = 1'b1;
        o_usesRs            = 1'b0;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LUI: begin
        o_sig[SIG_ALUSRC_IMM] = 1'b1;
        o_sig[SIG_REGWRITE]   = 1'b1;
        case (w_op)
          OP_ADDI:  o_alu = ALU_ADD;
          OP_ADDIU: o_alu = ALU_ADDU;
          OP_SLTI:  o_alu = ALU_SLT;
          OP_SLTIU: o_alu = ALU_SLTU;
          default: begin
            o_alu    = ALU_SLL;
            o_usesRs = 1'b0;
          end
        endcase
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        o_sig[SIG_ALUSRC_IMM] = 1'b1;
        o_sig[SIG_REGWRITE]   = 1'b1;
        o_sig[SIG_ZEXT]       = 1'b1;
        case (w_op)
          OP_ANDI: o_alu = ALU_AND;
          OP_ORI:  o_alu = ALU_OR;
          default: o_alu = ALU_XOR;
        endcase
      end
      default: begin
        o_usesRs  = 1'b0;
        o_illegal = 1'b1;
      end
    endcase
  end

  // Destination: $31 for links, rd for R-type, rt otherwise, $0 when nothing is written
  always_comb begin
    o_wr = 5'd0;
    if (o_sig[SIG_REGWRITE]) begin
      if (o_sig[SIG_LINK])           o_wr = 5'd31;
      else if (o_sig[SIG_REGDST_RD]) o_wr = w_rd;
      else                           o_wr = w_rt;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// ID-stage control unit with ID/EX register, load-use scoreboard and flush.
// Optional performance counters are enabled by defining CTRL_PIPE_PERF_EN.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int SIG_W    = 10,
  parameter int ALU_W    = 4,
  parameter int LOAD_LAT = 1
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  output logic             id_ready,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             ex_valid,
  output logic [SIG_W-1:0] ex_sig,
  output logic [ALU_W-1:0] ex_alu,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_wr,
  output logic [15:0]      ex_imm,
  output logic             ex_illegal
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [31:0]      perf_stall,
  output logic [31:0]      perf_flush
`endif
);

  logic [SIG_BITS-1:0] w_sig;
  logic [ALU_BITS-1:0] w_alu;
  logic [4:0]          w_wr;
  logic [15:0]         w_imm;
  logic                w_usesRs;
  logic                w_usesRt;
  logic                w_illegal;
  logic [4:0]          w_rs;
  logic [4:0]          w_rt;
  logic                w_match;
  logic                w_hazard;
  logic                w_issue;
  logic                w_slotValid [LOAD_LAT];
  logic [4:0]          w_slotDest  [LOAD_LAT];

  logic                r_valid;
  logic [SIG_W-1:0]    r_sig;
  logic [ALU_W-1:0]    r_alu;
  logic [4:0]          r_rs;
  logic [4:0]          r_rt;
  logic [4:0]          r_wr;
  logic [15:0]         r_imm;
  logic                r_illegal;

  ctrl_decode u_decode (
    .i_instr   (id_instr),
    .o_sig     (w_sig),
    .o_alu     (w_alu),
    .o_wr      (w_wr),
    .o_imm     (w_imm),
    .o_usesRs  (w_usesRs),
    .o_usesRt  (w_usesRt),
    .o_illegal (w_illegal)
  );

  assign w_rs = id_instr[F_RS_HI:F_RS_LO];
  assign w_rt = id_instr[F_RT_HI:F_RT_LO];

  // Slot 0 is the load currently sitting in ID/EX; no separate storage needed
  assign w_slotValid[0] = r_valid && r_sig[SIG_MEMTOREG] && (r_wr != 5'd0);
  assign w_slotDest[0]  = r_wr;

  // Older loads shift down the scoreboard whenever EX advances
  for (genvar g = 1; g < LOAD_LAT; g++) begin : g_slot
    logic       r_slotValid;
    logic [4:0] r_slotDest;

    // One scoreboard stage; holds while EX is stalled
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_slotValid <= 1'b0;
        r_slotDest  <= 5'd0;
      end else if (ex_ready) begin
        r_slotValid <= w_slotValid[g-1];
        r_slotDest  <= w_slotDest[g-1];
      end
    end

    assign w_slotValid[g] = r_slotValid;
    assign w_slotDest[g]  = r_slotDest;
  end

  // Compare each used, non-$0 source against every in-flight load
  always_comb begin
    w_match = 1'b0;
    for (int i = 0; i < LOAD_LAT; i++) begin
      if (w_slotValid[i]) begin
        if (w_usesRs && (w_rs != 5'd0) && (w_rs == w_slotDest[i])) w_match = 1'b1;
        if (w_usesRt && (w_rt != 5'd0) && (w_rt == w_slotDest[i])) w_match = 1'b1;
      end
    end
  end

  // A flush consumes and drops the ID instruction even when it would stall
  assign w_hazard = id_valid && w_match;
  assign id_ready = ex_ready && (!w_hazard || flush);
  assign w_issue  = id_valid && !w_hazard && !flush;

  // ID/EX register: load decoded fields or a zeroed bubble when EX advances
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_sig     <= '0;
      r_alu     <= '0;
      r_rs      <= 5'd0;
      r_rt      <= 5'd0;
      r_wr      <= 5'd0;
      r_imm     <= 16'd0;
      r_illegal <= 1'b0;
    end else if (ex_ready) begin
      if (w_issue) begin
        r_valid   <= 1'b1;
        r_sig     <= SIG_W'(w_sig);
        r_alu     <= ALU_W'(w_alu);
        r_rs      <= w_rs;
        r_rt      <= w_rt;
        r_wr      <= w_wr;
        r_imm     <= w_imm;
        r_illegal <= w_illegal;
      end else begin
        r_valid   <= 1'b0;
        r_sig     <= '0;
        r_alu     <= '0;
        r_rs      <= 5'd0;
        r_rt      <= 5'd0;
        r_wr      <= 5'd0;
        r_imm     <= 16'd0;
        r_illegal <= 1'b0;
      end
    end
  end

  assign ex_valid   = r_valid;
  assign ex_sig     = r_sig;
  assign ex_alu     = r_alu;
  assign ex_rs      = r_rs;
  assign ex_rt      = r_rt;
  assign ex_wr      = r_wr;
  assign ex_imm     = r_imm;
  assign ex_illegal = r_illegal;

`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] r_perfStall;
  logic [31:0] r_perfFlush;

  // Count load-use stall cycles and flushed live ID instructions
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perfStall <= 32'd0;
      r_perfFlush <= 32'd0;
    end else begin
      if (w_hazard && !flush && ex_ready) r_perfStall <= r_perfStall + 32'd1;
      if (flush && id_valid)              r_perfFlush <= r_perfFlush + 32'd1;
    end
  end

  assign perf_stall = r_perfStall;
  assign perf_flush = r_perfFlush;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed self-checking bench for ctrl_pipe. Two instances share the same
// stimulus: one with LOAD_LAT=1 and one with LOAD_LAT=3.
// Honours CTRL_PIPE_PERF_EN when the design is built with the counters.
module tb_ctrl_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        idValid = 1'b0;
  logic [31:0] idInstr = 32'd0;
  logic        flush = 1'b0;
  logic        exReady = 1'b1;

  logic        idReady1, exValid1, exIllegal1;
  logic [9:0]  exSig1;
  logic [3:0]  exAlu1;
  logic [4:0]  exRs1, exRt1, exWr1;
  logic [15:0] exImm1;

  logic        idReady3, exValid3, exIllegal3;
  logic [9:0]  exSig3;
  logic [3:0]  exAlu3;
  logic [4:0]  exRs3, exRt3, exWr3;
  logic [15:0] exImm3;

`ifdef CTRL_PIPE_PERF_EN
  logic [31:0] perfStall1, perfFlush1, perfStall3, perfFlush3;
`endif

  int testCount = 0;
  int failCount = 0;

  localparam logic [31:0] I_ADD    = 32'h00221820;
  localparam logic [31:0] I_LW5    = 32'h8C250000;
  localparam logic [31:0] I_ADDDEP = 32'h00A23020;
  localparam logic [31:0] I_LW0    = 32'h8C200000;
  localparam logic [31:0] I_ADDR0  = 32'h00023020;
  localparam logic [31:0] I_J      = 32'h08000010;
  localparam logic [31:0] I_BAD    = 32'hFC000000;

  ctrl_pipe #(.SIG_W(10), .ALU_W(4), .LOAD_LAT(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (idValid),
    .id_instr   (idInstr),
    .id_ready   (idReady1),
    .flush      (flush),
    .ex_ready   (exReady),
    .ex_valid   (exValid1),
    .ex_sig     (exSig1),
    .ex_alu     (exAlu1),
    .ex_rs      (exRs1),
    .ex_rt      (exRt1),
    .ex_wr      (exWr1),
    .ex_imm     (exImm1),
    .ex_illegal (exIllegal1)
`ifdef CTRL_PIPE_PERF_EN
    ,
    .perf_stall (perfStall1),
    .perf_flush (perfFlush1)
`endif
  );

  ctrl_pipe #(.SIG_W(10), .ALU_W(4), .LOAD_LAT(3)) dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (idValid),
    .id_instr   (idInstr),
    .id_ready   (idReady3),
    .flush      (flush),
    .ex_ready   (exReady),
    .ex_valid   (exValid3),
    .ex_sig     (exSig3),
    .ex_alu     (exAlu3),
    .ex_rs      (exRs3),
    .ex_rt      (exRt3),
    .ex_wr      (exWr3),
    .ex_imm     (exImm3),
    .ex_illegal (exIllegal3)
`ifdef CTRL_PIPE_PERF_EN
    ,
    .perf_stall (perfStall3),
    .perf_flush (perfFlush3)
`endif
  );

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  // Advance one rising edge, then settle just after it
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive the ID-side inputs away from the clock edge
  task automatic applyStimulus(input logic v, input logic [31:0] instr,
                               input logic fl, input logic rdy);
    idValid = v;
    idInstr = instr;
    flush   = fl;
    exReady = rdy;
    #1;
  endtask

  // Count one comparison and report it when it does not hold
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Idle the ID stage long enough for every scoreboard to empty
  task automatic drain;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    repeat (4) tick;
  endtask

  logic [31:0] tblInstr [8];
  logic [9:0]  tblSig   [8];
  logic [3:0]  tblAlu   [8];
  logic [4:0]  tblWr    [8];

  initial begin
    int bub1;
    int bub3;
    logic done1;
    logic done3;

    // instr, control word, ALU op, destination
    tblInstr[0] = 32'h03E00008; tblSig[0] = 10'h001; tblAlu[0] = 4'd0; tblWr[0] = 5'd0;  // JR $31
    tblInstr[1] = 32'h0C000010; tblSig[1] = 10'h049; tblAlu[1] = 4'd0; tblWr[1] = 5'd31; // JAL
    tblInstr[2] = 32'h3C041234; tblSig[2] = 10'h028; tblAlu[2] = 4'd7; tblWr[2] = 5'd4;  // LUI $4
    tblInstr[3] = 32'h34221234; tblSig[3] = 10'h128; tblAlu[3] = 4'd5; tblWr[3] = 5'd2;  // ORI $2,$1
    tblInstr[4] = 32'h14220004; tblSig[4] = 10'h202; tblAlu[4] = 4'd0; tblWr[4] = 5'd0;  // BNE $1,$2
    tblInstr[5] = 32'hAC250004; tblSig[5] = 10'h024; tblAlu[5] = 4'd2; tblWr[5] = 5'd0;  // SW $5,4($1)
    tblInstr[6] = 32'h20270005; tblSig[6] = 10'h028; tblAlu[6] = 4'd2; tblWr[6] = 5'd7;  // ADDI $7,$1
    tblInstr[7] = 32'h2C270005; tblSig[7] = 10'h028; tblAlu[7] = 4'd9; tblWr[7] = 5'd7;  // SLTIU $7,$1

    // Reset state
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1);
    repeat (2) tick;
    rst_n = 1'b1;
    #1;
    checkOutput("rst_valid1", exValid1, 1'b0);
    checkOutput("rst_valid3", exValid3, 1'b0);
    checkOutput("rst_sig1", exSig1, 10'h0);
    checkOutput("rst_wr3", exWr3, 5'd0);
    checkOutput("rst_ready1", idReady1, 1'b1);

    // Plain ADD issues one cycle later
    applyStimulus(1'b1, I_ADD, 1'b0, 1'b1);
    checkOutput("add_ready", idReady1, 1'b1);
    tick;
    checkOutput("add_valid", exValid1, 1'b1);
    checkOutput("add_sig", exSig1, 10'h088);
    checkOutput("add_alu", exAlu1, 4'd1);
    checkOutput("add_wr", exWr1, 5'd3);
    checkOutput("add_rs", exRs1, 5'd1);
    checkOutput("add_rt", exRt1, 5'd2);
    checkOutput("add_imm", exImm1, 16'h1820);
    checkOutput("add_valid3", exValid3, 1'b1);

    // LW $5 then dependent ADD: one bubble at LOAD_LAT=1, three at LOAD_LAT=3
    applyStimulus(1'b1, I_LW5, 1'b0, 1'b1);
    tick;
    checkOutput("lw_sig", exSig1, 10'h038);
    checkOutput("lw_alu", exAlu1, 4'd2);
    checkOutput("lw_wr", exWr1, 5'd5);
    applyStimulus(1'b1, I_ADDDEP, 1'b0, 1'b1);
    checkOutput("lu_ready1_c0", idReady1, 1'b0);
    checkOutput("lu_ready3_c0", idReady3, 1'b0);
    tick;
    checkOutput("lu_valid1_c1", exValid1, 1'b0);
    checkOutput("lu_valid3_c1", exValid3, 1'b0);
    checkOutput("lu_ready1_c1", idReady1, 1'b1);
    checkOutput("lu_ready3_c1", idReady3, 1'b0);
    tick;
    checkOutput("lu_valid1_c2", exValid1, 1'b1);
    checkOutput("lu_wr1_c2", exWr1, 5'd6);
    checkOutput("lu_valid3_c2", exValid3, 1'b0);
    checkOutput("lu_ready3_c2", idReady3, 1'b0);
    tick;
    checkOutput("lu_valid3_c3", exValid3, 1'b0);
    checkOutput("lu_ready3_c3", idReady3, 1'b1);
    tick;
    checkOutput("lu_valid3_c4", exValid3, 1'b1);
    checkOutput("lu_wr3_c4", exWr3, 5'd6);
    drain;

    // LW $0 never blocks; a J after LW $5 uses no sources
    applyStimulus(1'b1, I_LW0, 1'b0, 1'b1);
    tick;
    checkOutput("lw0_wr3", exWr3, 5'd0);
    applyStimulus(1'b1, I_ADDR0, 1'b0, 1'b1);
    checkOutput("lw0_ready3", idReady3, 1'b1);
    tick;
    checkOutput("lw0_valid3", exValid3, 1'b1);
    checkOutput("lw0_addwr3", exWr3, 5'd6);
    applyStimulus(1'b1, I_LW5, 1'b0, 1'b1);
    tick;
    applyStimulus(1'b1, I_J, 1'b0, 1'b1);
    checkOutput("j_ready3", idReady3, 1'b1);
    tick;
    checkOutput("j_valid3", exValid3, 1'b1);
    checkOutput("j_sig3", exSig3, 10'h001);
    drain;

    // Decode table through the pipeline, one instruction per cycle
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, tblInstr[k], 1'b0, 1'b1);
      tick;
      checkOutput($sformatf("dec%0d_valid", k), exValid1, 1'b1);
      checkOutput($sformatf("dec%0d_sig", k), exSig1, tblSig[k]);
      checkOutput($sformatf("dec%0d_alu", k), exAlu1, tblAlu[k]);
      checkOutput($sformatf("dec%0d_wr", k), exWr1, tblWr[k]);
    end
    drain;

    // Flush beats a hazard; older loads in slots >= 1 still block
    applyStimulus(1'b1, I_LW5, 1'b0, 1'b1);
    tick;
    applyStimulus(1'b1, I_ADDDEP, 1'b1, 1'b1);
    checkOutput("fl_ready1", idReady1, 1'b1);
    checkOutput("fl_ready3", idReady3, 1'b1);
    tick;
    checkOutput("fl_valid1", exValid1, 1'b0);
    checkOutput("fl_valid3", exValid3, 1'b0);
    applyStimulus(1'b1, I_ADDDEP, 1'b0, 1'b1);
    checkOutput("fl_post_ready1", idReady1, 1'b1);
    checkOutput("fl_post_ready3_a", idReady3, 1'b0);
    tick;
    checkOutput("fl_post_valid1", exValid1, 1'b1);
    checkOutput("fl_post_ready3_b", idReady3, 1'b0);
    tick;
    checkOutput("fl_post_ready3_c", idReady3, 1'b1);
    tick;
    checkOutput("fl_post_valid3", exValid3, 1'b1);
    checkOutput("fl_post_wr3", exWr3, 5'd6);
    drain;

    // EX back-pressure after LW freezes everything; bubbles unchanged on release
    applyStimulus(1'b1, I_LW5, 1'b0, 1'b1);
    tick;
    applyStimulus(1'b1, I_ADDDEP, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("frz%0d_ready1", k), idReady1, 1'b0);
      checkOutput($sformatf("frz%0d_ready3", k), idReady3, 1'b0);
      tick;
      checkOutput($sformatf("frz%0d_valid3", k), exValid3, 1'b1);
      checkOutput($sformatf("frz%0d_wr3", k), exWr3, 5'd5);
      checkOutput($sformatf("frz%0d_sig1", k), exSig1, 10'h038);
    end
    applyStimulus(1'b1, I_ADDDEP, 1'b0, 1'b1);
    bub1 = 0;
    bub3 = 0;
    done1 = 1'b0;
    done3 = 1'b0;
    for (int k = 0; k < 10 && !(done1 && done3); k++) begin
      tick;
      if (!done1) begin
        if (exValid1 && exWr1 == 5'd6) done1 = 1'b1;
        else bub1++;
      end
      if (!done3) begin
        if (exValid3 && exWr3 == 5'd6) done3 = 1'b1;
        else bub3++;
      end
    end
    checkOutput("frz_issued1", done1, 1'b1);
    checkOutput("frz_issued3", done3, 1'b1);
    checkOutput("frz_bubbles1", bub1, 32'd1);
    checkOutput("frz_bubbles3", bub3, 32'd3);
    drain;

    // Undecodable opcode
    applyStimulus(1'b1, I_BAD, 1'b0, 1'b1);
    tick;
    checkOutput("ill_valid", exValid1, 1'b1);
    checkOutput("ill_flag", exIllegal1, 1'b1);
    checkOutput("ill_sig", exSig1, 10'h0);
    checkOutput("ill_alu", exAlu1, 4'd0);
    checkOutput("ill_wr", exWr1, 5'd0);
    drain;

`ifdef CTRL_PIPE_PERF_EN
    checkOutput("perf_flush1", perfFlush1, 32'd1);
    checkOutput("perf_flush3", perfFlush3, 32'd1);
    checkOutput("perf_stall1", perfStall1, 32'd2);
    checkOutput("perf_stall3", perfStall3, 32'd8);
`endif

    // Reset in the middle of a load-use stall clears the scoreboard
    applyStimulus(1'b1, I_LW5, 1'b0, 1'b1);
    tick;
    applyStimulus(1'b1, I_ADDDEP, 1'b0, 1'b1);
    checkOutput("rs_ready3_pre", idReady3, 1'b0);
    rst_n = 1'b0;
    tick;
    checkOutput("rs_valid1", exValid1, 1'b0);
    checkOutput("rs_valid3", exValid3, 1'b0);
    checkOutput("rs_sig3", exSig3, 10'h0);
    checkOutput("rs_wr3", exWr3, 5'd0);
    checkOutput("rs_rs3", exRs3, 5'd0);
    checkOutput("rs_imm3", exImm3, 16'h0);
`ifdef CTRL_PIPE_PERF_EN
    checkOutput("rs_perf_flush3", perfFlush3, 32'd0);
`endif
    rst_n = 1'b1;
    #1;
    checkOutput("rs_ready3_post", idReady3, 1'b1);
    checkOutput("rs_ready1_post", idReady1, 1'b1);
    tick;
    checkOutput("rs_issue_valid3", exValid3, 1'b1);
    checkOutput("rs_issue_wr3", exWr3, 5'd6);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
